// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - ID-stage hazard detection and operand forwarding select for the 5-stage pipeline
// Optional feature macro: JAL_FWD_EN (forward pc+8 from WB as ctr 7 instead of stalling).
module hazard_fwd_unit #(
   parameter int REG_AW = 5,
   parameter int CTR_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] A1_ID,
   input  logic [REG_AW-1:0] A2_ID,
   input  logic              use_rs_ID,
   input  logic              use_rt_ID,
   input  logic              RegWrite_ID,
   input  logic [REG_AW-1:0] A3_ID,
   input  logic [1:0]        MemtoReg_ID,
   output logic              Stall,
   output logic [CTR_W-1:0]  Rd1_Fwd_ctr,
   output logic [CTR_W-1:0]  Rd2_Fwd_ctr
);

   logic              r_v_ex, r_v_mem, r_v_wb;
   logic [REG_AW-1:0] r_a3_ex, r_a3_mem, r_a3_wb;
   logic [1:0]        r_mtr_ex, r_mtr_mem, r_mtr_wb;

   logic [CTR_W:0]    w_rs, w_rt;

   // Each lookup returns {stall, ctr} for a matching writer in that stage.
   function automatic logic [CTR_W:0] f_ex(input logic [1:0] mtr);
      if (mtr == 2'd3) return {1'b0, CTR_W'(1)};
      return {1'b1, CTR_W'(0)};
   endfunction

   function automatic logic [CTR_W:0] f_mem(input logic [1:0] mtr);
      case (mtr)
         2'd3:    return {1'b0, CTR_W'(2)};
         2'd0:    return {1'b0, CTR_W'(3)};
         default: return {1'b1, CTR_W'(0)};
      endcase
   endfunction

   function automatic logic [CTR_W:0] f_wb(input logic [1:0] mtr);
      case (mtr)
         2'd3:    return {1'b0, CTR_W'(4)};
         2'd0:    return {1'b0, CTR_W'(5)};
         2'd1:    return {1'b0, CTR_W'(6)};
`ifdef JAL_FWD_EN
         default: return {1'b0, CTR_W'(7)};
`else
         default: return {1'b1, CTR_W'(0)};
`endif
      endcase
   endfunction

   // A nonzero read address matching a3 implies a3 != 0, so liveness reduces to valid.
   function automatic logic [CTR_W:0] f_resolve(
      input logic [REG_AW-1:0] a,
      input logic              u,
      input logic              v_ex,  input logic [REG_AW-1:0] a3_ex,  input logic [1:0] mtr_ex,
      input logic              v_mem, input logic [REG_AW-1:0] a3_mem, input logic [1:0] mtr_mem,
      input logic              v_wb,  input logic [REG_AW-1:0] a3_wb,  input logic [1:0] mtr_wb
   );
      if (!u || a == '0)              return '0;
      if (v_ex  && a3_ex  == a)       return f_ex(mtr_ex);
      if (v_mem && a3_mem == a)       return f_mem(mtr_mem);
      if (v_wb  && a3_wb  == a)       return f_wb(mtr_wb);
      return '0;
   endfunction

   always_comb begin
      w_rs = f_resolve(A1_ID, use_rs_ID,
                       r_v_ex, r_a3_ex, r_mtr_ex, r_v_mem, r_a3_mem, r_mtr_mem,
                       r_v_wb, r_a3_wb, r_mtr_wb);
      w_rt = f_resolve(A2_ID, use_rt_ID,
                       r_v_ex, r_a3_ex, r_mtr_ex, r_v_mem, r_a3_mem, r_mtr_mem,
                       r_v_wb, r_a3_wb, r_mtr_wb);
   end

   assign Stall       = w_rs[CTR_W] | w_rt[CTR_W];
   assign Rd1_Fwd_ctr = w_rs[CTR_W-1:0];
   assign Rd2_Fwd_ctr = w_rt[CTR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v_ex  <= 1'b0;
         r_v_mem <= 1'b0;
         r_v_wb  <= 1'b0;
      end else begin
         r_v_wb    <= r_v_mem;
         r_a3_wb   <= r_a3_mem;
         r_mtr_wb  <= r_mtr_mem;
         r_v_mem   <= r_v_ex;
         r_a3_mem  <= r_a3_ex;
         r_mtr_mem <= r_mtr_ex;
         r_v_ex    <= RegWrite_ID & ~Stall;
         r_a3_ex   <= A3_ID;
         r_mtr_ex  <= MemtoReg_ID;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed and randomized checks of hazard_fwd_unit against a writer-queue model
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] A1_ID, A2_ID, A3_ID;
   logic       use_rs_ID, use_rt_ID, RegWrite_ID;
   logic [1:0] MemtoReg_ID;
   logic       Stall;
   logic [2:0] Rd1_Fwd_ctr, Rd2_Fwd_ctr;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_fwd_unit dut (
      .clk(clk), .rst(rst),
      .A1_ID(A1_ID), .A2_ID(A2_ID),
      .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
      .RegWrite_ID(RegWrite_ID), .A3_ID(A3_ID), .MemtoReg_ID(MemtoReg_ID),
      .Stall(Stall), .Rd1_Fwd_ctr(Rd1_Fwd_ctr), .Rd2_Fwd_ctr(Rd2_Fwd_ctr)
   );

   always #5 clk = ~clk;

   typedef struct { bit v; int a3; int mtr; } writer_t;
   writer_t pipe[3];       // index 0 = youngest (EX), 2 = oldest (WB)
   int      tab[3][4];     // forwarding code by stage and source; -1 means stall

`ifdef JAL_FWD_EN
   localparam int JAL_STALLS = 2;
   localparam int JAL_CTR    = 7;
`else
   localparam int JAL_STALLS = 3;
   localparam int JAL_CTR    = 0;
`endif

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_res(input int a, input bit u);
      if (!u || a == 0) return 0;
      for (int s = 0; s < 3; s++)
         if (pipe[s].v && pipe[s].a3 != 0 && pipe[s].a3 == a)
            return tab[s][pipe[s].mtr];
      return 0;
   endfunction

   task automatic drive(input int a1, input int a2, input bit u1, input bit u2,
                        input bit rw, input int a3, input int mtr);
      A1_ID = 5'(a1); A2_ID = 5'(a2); use_rs_ID = u1; use_rt_ID = u2;
      RegWrite_ID = rw; A3_ID = 5'(a3); MemtoReg_ID = 2'(mtr);
   endtask

   // Compare against the model, clock once, then advance the model.
   task automatic tick(input string tag);
      int  r1, r2;
      bit  st;
      #1;
      r1 = model_res(int'(A1_ID), use_rs_ID);
      r2 = model_res(int'(A2_ID), use_rt_ID);
      st = (r1 < 0) || (r2 < 0);
      check({tag, "_stall"}, int'(Stall), int'(st));
      if (r1 >= 0) check({tag, "_rd1"}, int'(Rd1_Fwd_ctr), r1);
      if (r2 >= 0) check({tag, "_rd2"}, int'(Rd2_Fwd_ctr), r2);
      @(posedge clk);
      if (rst) begin
         for (int s = 0; s < 3; s++) pipe[s].v = 0;
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0].v   = RegWrite_ID && !st;
         pipe[0].a3  = int'(A3_ID);
         pipe[0].mtr = int'(MemtoReg_ID);
      end
      #1;
   endtask

   task automatic flush();
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick("flush");
   endtask

   initial begin
      tab[0] = '{-1, -1, -1, 1};
      tab[1] = '{3, -1, -1, 2};
      tab[2] = '{5, 6, JAL_CTR == 7 ? 7 : -1, 4};
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0};

      // reset with live writes on the ID side
      rst = 1'b1;
      drive(8, 8, 1, 1, 1, 8, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_stall", int'(Stall), 0);
         check("rst_rd1", int'(Rd1_Fwd_ctr), 0);
         check("rst_rd2", int'(Rd2_Fwd_ctr), 0);
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      for (int a = 0; a < 32; a += 5) begin
         drive(a, 0, 1, 0, 0, 0, 0);
         #1 check("post_rst_rd1", int'(Rd1_Fwd_ctr), 0);
      end

      // lui $8 ; beq $8,$9
      drive(0, 0, 0, 0, 1, 8, 3);  tick("lui");
      drive(8, 9, 1, 1, 0, 0, 0);
      #1 check("lui_ex_rd1", int'(Rd1_Fwd_ctr), 1);
      check("lui_ex_stall", int'(Stall), 0);
      tick("lui_ex");
      check("lui_mem_rd1", int'(Rd1_Fwd_ctr), 2);
      tick("lui_mem");
      check("lui_wb_rd1", int'(Rd1_Fwd_ctr), 4);
      flush();

      // addu $8 ; beq $8
      drive(0, 0, 0, 0, 1, 8, 0);  tick("addu");
      drive(8, 0, 1, 1, 0, 0, 0);
      #1 check("addu_stall1", int'(Stall), 1);
      tick("addu_s");
      check("addu_stall2", int'(Stall), 0);
      check("addu_rd1", int'(Rd1_Fwd_ctr), 3);
      tick("addu_f");
      drive(0, 0, 0, 0, 1, 0, 0);  tick("addu0");
      drive(0, 0, 1, 1, 0, 0, 0);
      #1 check("zero_stall", int'(Stall), 0);
      check("zero_rd1", int'(Rd1_Fwd_ctr), 0);
      flush();

      // lw $9 ; bne $0,$9
      drive(0, 0, 0, 0, 1, 9, 1);  tick("lw");
      drive(0, 9, 1, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1 check("lw_stall", int'(Stall), 1);
         tick("lw_s");
      end
      check("lw_stall_end", int'(Stall), 0);
      check("lw_rd2", int'(Rd2_Fwd_ctr), 6);
      flush();

      // youngest writer wins: lw $8 then addu $8
      drive(0, 0, 0, 0, 1, 8, 1);  tick("yw_lw");
      drive(0, 0, 0, 0, 1, 8, 0);  tick("yw_addu");
      drive(8, 0, 1, 0, 0, 0, 0);
      #1 check("yw_stall", int'(Stall), 1);
      tick("yw_s");
      check("yw_stall_end", int'(Stall), 0);
      check("yw_rd1", int'(Rd1_Fwd_ctr), 3);
      flush();

      // jal ; jr $31
      drive(0, 0, 0, 0, 1, 31, 2); tick("jal");
      drive(31, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < JAL_STALLS; i++) begin
         #1 check("jal_stall", int'(Stall), 1);
         tick("jal_s");
      end
      check("jal_stall_end", int'(Stall), 0);
      check("jal_rd1", int'(Rd1_Fwd_ctr), JAL_CTR);
      flush();

      // randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 400; i++) begin
         int sel[5];
         sel = '{0, 1, 2, 3, 31};
         rst = ($urandom_range(0, 39) == 0);
         drive(sel[$urandom_range(0, 4)], sel[$urandom_range(0, 4)],
               1'($urandom), 1'($urandom), 1'($urandom),
               sel[$urandom_range(0, 4)], int'($urandom_range(0, 3)));
         tick("rand");
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
